// File: rtl/n4_neg_arbiter.sv
// Round-robin share of one excess-8 negator between requesters A/B; N4_NEG_ARB_OWCNT_EN adds a saturating overflow counter.
// Result+ack one edge after the grant; a waiting requester holds req until the current ack falls (4-phase handshake).
module n4_c2_negator (
    input  logic [3:0] i_x,
    output logic [3:0] o_z,
    output logic       o_ow
);
    assign o_z  = 4'd0 - i_x;
    // -8 (0000) has no positive counterpart in excess-8
    assign o_ow = (i_x == 4'd0);
endmodule

module n4_neg_arbiter (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_a,
    input  logic [3:0] xa3_xa0,
    output logic       ack_a,
    output logic [3:0] za3_za0,
    output logic       ow_a,
    input  logic       req_b,
    input  logic [3:0] xb3_xb0,
    output logic       ack_b,
    output logic [3:0] zb3_zb0,
    output logic       ow_b,
`ifdef N4_NEG_ARB_OWCNT_EN
    output logic [7:0] owc7_owc0,
`endif
    output logic       busy
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_ACK} state_t;

    state_t     r_state;
    logic [3:0] r_op;
    logic       r_sel;
    logic       r_prio;
    logic       r_ack_a, r_ack_b;
    logic [3:0] r_za, r_zb;
    logic       r_ow_a, r_ow_b;

    logic [3:0] w_z;
    logic       w_ow;
    logic       w_grant_b;
    logic       w_req_sel;

    n4_c2_negator u_neg (
        .i_x  (r_op),
        .o_z  (w_z),
        .o_ow (w_ow)
    );

    // B wins when it is the only requester, or when both ask and B holds priority
    assign w_grant_b = req_b & (~req_a | r_prio);
    assign w_req_sel = r_sel ? req_b : req_a;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_op    <= 4'd0;
            r_sel   <= 1'b0;
            r_prio  <= 1'b0;
            r_ack_a <= 1'b0;
            r_ack_b <= 1'b0;
            r_za    <= 4'd0;
            r_zb    <= 4'd0;
            r_ow_a  <= 1'b0;
            r_ow_b  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_a | req_b) begin
                        r_sel   <= w_grant_b;
                        r_op    <= w_grant_b ? xb3_xb0 : xa3_xa0;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (r_sel) begin
                        r_zb    <= w_z;
                        r_ow_b  <= w_ow;
                        r_ack_b <= 1'b1;
                    end else begin
                        r_za    <= w_z;
                        r_ow_a  <= w_ow;
                        r_ack_a <= 1'b1;
                    end
                    r_state <= S_ACK;
                end
                S_ACK: begin
                    if (!w_req_sel) begin
                        r_ack_a <= 1'b0;
                        r_ack_b <= 1'b0;
                        r_prio  <= ~r_sel;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef N4_NEG_ARB_OWCNT_EN
    logic [7:0] r_owc;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_owc <= 8'd0;
        end else if (r_state == S_CALC && w_ow && r_owc != 8'hFF) begin
            r_owc <= r_owc + 8'd1;
        end
    end

    assign owc7_owc0 = r_owc;
`endif

    assign ack_a   = r_ack_a;
    assign ack_b   = r_ack_b;
    assign za3_za0 = r_za;
    assign zb3_zb0 = r_zb;
    assign ow_a    = r_ow_a;
    assign ow_b    = r_ow_b;
    assign busy    = (r_state != S_IDLE);
endmodule

// File: tb/tb_n4_neg_arbiter.sv
// Randomized bench for n4_neg_arbiter against a transaction-level reference model.
module tb_n4_neg_arbiter;
    logic       clock = 1'b0;
    logic       reset;
    logic       req_a, req_b;
    logic [3:0] xa3_xa0, xb3_xb0;
    logic       ack_a, ack_b, ow_a, ow_b, busy;
    logic [3:0] za3_za0, zb3_zb0;
`ifdef N4_NEG_ARB_OWCNT_EN
    logic [7:0] owc7_owc0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // reference model: per-requester result registers, priority, operands
    int m_prio;
    int m_z[2];
    int m_ow[2];
    int m_x[2];
    int m_owc;

    n4_neg_arbiter dut (
        .clock   (clock),
        .reset   (reset),
        .req_a   (req_a),
        .xa3_xa0 (xa3_xa0),
        .ack_a   (ack_a),
        .za3_za0 (za3_za0),
        .ow_a    (ow_a),
        .req_b   (req_b),
        .xb3_xb0 (xb3_xb0),
        .ack_b   (ack_b),
        .zb3_zb0 (zb3_zb0),
        .ow_b    (ow_b),
`ifdef N4_NEG_ARB_OWCNT_EN
        .owc7_owc0 (owc7_owc0),
`endif
        .busy    (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int neg_ref(input int x);
        return (16 - x) % 16;
    endfunction

    function automatic int get_ack(input int who);
        return (who == 0) ? int'(ack_a) : int'(ack_b);
    endfunction

    task automatic model_reset();
        m_prio = 0;
        m_z[0] = 0; m_z[1] = 0;
        m_ow[0] = 0; m_ow[1] = 0;
        m_owc = 0;
    endtask

    task automatic model_calc(input int who);
        m_z[who]  = neg_ref(m_x[who]);
        m_ow[who] = (m_x[who] == 0) ? 1 : 0;
        if (m_ow[who] == 1 && m_owc < 255) m_owc++;
    endtask

    task automatic check_outs();
        chk("za", int'(za3_za0), m_z[0]);
        chk("ow_a", int'(ow_a), m_ow[0]);
        chk("zb", int'(zb3_zb0), m_z[1]);
        chk("ow_b", int'(ow_b), m_ow[1]);
`ifdef N4_NEG_ARB_OWCNT_EN
        chk("owc", int'(owc7_owc0), m_owc);
`endif
    endtask

    task automatic drop_req(input int who);
        if (who == 0) req_a = 1'b0;
        else          req_b = 1'b0;
    endtask

    // wait for who's ack, check the result, hold a random time, drop req, check ack falls
    task automatic serve(input int who, input int exp_lat);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (get_ack(who) == 0 && n < 30);
        chk("ack_latency", n, exp_lat);
        model_calc(who);
        check_outs();
        chk("other_ack", get_ack(1 - who), 0);
        chk("busy_in_ack", int'(busy), 1);
        repeat ($urandom_range(0, 2)) begin
            @(negedge clock);
            chk("ack_hold", get_ack(who), 1);
        end
        drop_req(who);
        @(negedge clock);
        chk("ack_fall", get_ack(who), 0);
        chk("busy_idle", int'(busy), 0);
        m_prio = 1 - who;
    endtask

    task automatic round(input int ra, input int rb, input int xa, input int xb);
        int first;
        m_x[0] = xa;
        m_x[1] = xb;
        @(posedge clock);
        #1;
        xa3_xa0 = 4'(xa);
        xb3_xb0 = 4'(xb);
        req_a   = (ra != 0);
        req_b   = (rb != 0);
        first   = (ra != 0 && rb != 0) ? m_prio : ((ra != 0) ? 0 : 1);
        serve(first, 3);
        if (ra != 0 && rb != 0) serve(1 - first, 2);
    endtask

    function automatic int rand_x();
        return ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 15));
    endfunction

    task automatic fairness(input int count);
        int exp_who = m_prio;
        int who, n;
        m_x[0] = rand_x();
        m_x[1] = rand_x();
        @(posedge clock);
        #1;
        xa3_xa0 = 4'(m_x[0]);
        xb3_xb0 = 4'(m_x[1]);
        req_a = 1'b1;
        req_b = 1'b1;
        for (int i = 0; i < count; i++) begin
            n = 0;
            do begin
                @(negedge clock);
                n++;
            end while (ack_a == 1'b0 && ack_b == 1'b0 && n < 30);
            chk("fair_latency", n, (i == 0) ? 3 : 2);
            who = (ack_b == 1'b1) ? 1 : 0;
            chk("grant_order", who, exp_who);
            model_calc(exp_who);
            check_outs();
            drop_req(who);
            @(negedge clock);
            chk("fair_ack_fall", int'(ack_a | ack_b), 0);
            m_prio  = 1 - exp_who;
            if (i < count - 1) begin
                m_x[who] = rand_x();
                if (who == 0) begin xa3_xa0 = 4'(m_x[0]); req_a = 1'b1; end
                else          begin xb3_xb0 = 4'(m_x[1]); req_b = 1'b1; end
            end else begin
                req_a = 1'b0;
                req_b = 1'b0;
            end
            exp_who = 1 - exp_who;
        end
        @(negedge clock);
        chk("fair_idle", int'(busy), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int sel;
        reset = 1'b1;
        req_a = 1'b0;
        req_b = 1'b0;
        xa3_xa0 = 4'd0;
        xb3_xb0 = 4'd0;
        model_reset();
        m_x[0] = 0; m_x[1] = 0;
        #1;
        chk("rst_ack_a", int'(ack_a), 0);
        chk("rst_ack_b", int'(ack_b), 0);
        chk("rst_busy", int'(busy), 0);
        check_outs();
        repeat (3) @(negedge clock);
        reset = 1'b0;

        // simultaneous requests right after reset: A first, B next
        round(1, 1, 7, 8);
        chk("tp_za_0111", int'(za3_za0), 9);
        chk("tp_zb_1000", int'(zb3_zb0), 8);
        round(1, 0, 3, 0);
        chk("tp_za_0011", int'(za3_za0), 13);
        round(0, 1, 0, 0);
        chk("tp_ow_b_0000", int'(ow_b), 1);

        fairness(6);

        // req falls before ack: transaction still completes, ack pulses one cycle
        m_x[0] = rand_x();
        @(posedge clock);
        #1;
        xa3_xa0 = 4'(m_x[0]);
        req_a = 1'b1;
        @(posedge clock);
        #1;
        req_a = 1'b0;
        @(negedge clock);
        chk("viol_ack_early", int'(ack_a), 0);
        @(negedge clock);
        chk("viol_ack_rise", int'(ack_a), 1);
        model_calc(0);
        check_outs();
        @(negedge clock);
        chk("viol_ack_fall", int'(ack_a), 0);
        chk("viol_busy", int'(busy), 0);
        m_prio = 1;

        // reset while A is in ACK, req_a held across it
        m_x[0] = 5;
        @(posedge clock);
        #1;
        xa3_xa0 = 4'(m_x[0]);
        req_a = 1'b1;
        repeat (3) @(negedge clock);
        chk("pre_rst_ack", int'(ack_a), 1);
        reset = 1'b1;
        #1;
        model_reset();
        chk("mid_rst_ack", int'(ack_a), 0);
        chk("mid_rst_busy", int'(busy), 0);
        check_outs();
        @(negedge clock);
        reset = 1'b0;
        serve(0, 2);

        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(1, 3);
            round(sel & 1, sel >> 1, rand_x(), rand_x());
        end

`ifdef N4_NEG_ARB_OWCNT_EN
        for (int i = 0; i < 260; i++) begin
            round((i % 2 == 0) ? 1 : 0, (i % 2 == 1) ? 1 : 0, 0, 0);
        end
        chk("owc_saturated", int'(owc7_owc0), 255);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
